// File: rtl/demux_1to4_buf.sv
// rtl/demux_1to4_buf.sv - 1-to-4 stream demultiplexer with one-entry holding register per channel (optional macro DEMUX_STATS_EN)
module demux_1to4_buf #(
    parameter int WIDTH     = 27,
    parameter int CNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic             out_valid3,
`ifdef DEMUX_STATS_EN
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1,
    output logic [CNT_WIDTH-1:0] cnt2,
    output logic [CNT_WIDTH-1:0] cnt3,
`endif
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    input  logic             out_ready3
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

    ch_state_e        state_q [4];
    ch_state_e        state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [3:0]       ready_vec;
    logic [3:0]       valid_vec;
    logic [3:0]       load;
    logic [3:0]       drain;

    assign ready_vec = {out_ready3, out_ready2, out_ready1, out_ready0};

    // Channel occupancy flags derived from the per-channel state
    always_comb begin
        valid_vec = '0;
        for (int n = 0; n < 4; n++) begin
            valid_vec[n] = (state_q[n] == FULL);
        end
    end

    // Only the selected channel can push back on the producer
    assign in_ready = !valid_vec[select] || ready_vec[select];

    // Next-state: a refill wins over a drain so a streaming channel stays FULL
    always_comb begin
        load  = '0;
        drain = valid_vec & ready_vec;
        if (in_valid && in_ready) begin
            load[select] = 1'b1;
        end
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            if (load[n]) begin
                state_d[n] = FULL;
            end else if (drain[n]) begin
                state_d[n] = EMPTY;
            end
        end
    end

    // State register; reset discards anything held
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst) begin
                state_q[n] <= EMPTY;
            end else begin
                state_q[n] <= state_d[n];
            end
        end
    end

    // Payload registers capture only on a load and otherwise hold
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst) begin
                data_q[n] <= '0;
            end else if (load[n]) begin
                data_q[n] <= in_data;
            end
        end
    end

    assign out_data0  = data_q[0];
    assign out_data1  = data_q[1];
    assign out_data2  = data_q[2];
    assign out_data3  = data_q[3];
    assign out_valid0 = valid_vec[0];
    assign out_valid1 = valid_vec[1];
    assign out_valid2 = valid_vec[2];
    assign out_valid3 = valid_vec[3];

`ifdef DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [4];

    // Per-channel output transfer counters; clear beats increment, wrap naturally
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst || cnt_clr) begin
                cnt_q[n] <= '0;
            end else if (drain[n]) begin
                cnt_q[n] <= cnt_q[n] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule
